// File: rtl/xnor_cmp_scheduler.sv
// Round-robin shared bit-serial XNOR equality comparator; req -> done in WIDTH+1 cycles, fixed.
// No queueing: requests seen only in IDLE, a held req is re-arbitrated on return to IDLE.
module xnor_cmp_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             eq
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             id_q, id_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic             eq_q, eq_d;
  logic             sel;
  logic             bit_ok;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sha_d     = sha_q;
    shb_d     = shb_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    id_d      = id_q;
    gnt_d     = 2'b00;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    eq_d      = eq_q;
    sel       = 1'b0;
    bit_ok    = ~(sha_q[0] ^ shb_q[0]);

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Contention resolved by the pointer; a lone requester always wins.
          sel     = (req0 && req1) ? ptr_q : req1;
          sha_d   = sel ? a1 : a0;
          shb_d   = sel ? b1 : b0;
          cnt_d   = '0;
          acc_d   = 1'b1;
          gnt_d   = sel ? 2'b10 : 2'b01;
          id_d    = sel;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = acc_q & bit_ok;
        sha_d = sha_q >> 1;
        shb_d = shb_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          eq_d      = acc_q & bit_ok;
          done_id_d = id_q;
          ptr_d     = ~id_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      sha_q     <= '0;
      shb_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= 1'b1;
      id_q      <= 1'b0;
      gnt_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      eq_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sha_q     <= sha_d;
      shb_q     <= shb_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      id_q      <= id_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      eq_q      <= eq_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign eq      = eq_q;

endmodule

// File: tb/tb_xnor_cmp_scheduler.sv
// Directed bench for xnor_cmp_scheduler (WIDTH=8); inputs driven and outputs sampled on falling edges.
module tb_xnor_cmp_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] a0, b0, a1, b1;
  logic [1:0] gnt;
  logic       busy, done, done_id, eq;

  int n_chk  = 0;
  int n_fail = 0;

  xnor_cmp_scheduler #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .eq(eq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".gnt"}, {6'd0, gnt}, 8'd0);
    check({tag, ".busy"}, {7'd0, busy}, 8'd0);
    check({tag, ".done"}, {7'd0, done}, 8'd0);
    check({tag, ".done_id"}, {7'd0, done_id}, 8'd0);
    check({tag, ".eq"}, {7'd0, eq}, 8'd0);
  endtask

  // Issues one request from IDLE at a falling edge and checks the whole compare window.
  task automatic do_cmp(input string tag, input logic port, input logic [7:0] a,
                        input logic [7:0] b, input logic exp_eq);
    if (port) begin req1 = 1'b1; a1 = a; b1 = b; end
    else      begin req0 = 1'b1; a0 = a; b0 = b; end
    @(negedge clk);
    check({tag, ".gnt"}, {6'd0, gnt}, port ? 8'd2 : 8'd1);
    check({tag, ".busy1"}, {7'd0, busy}, 8'd1);
    req0 = 1'b0; req1 = 1'b0;
    a0 = ~a; b0 = b; a1 = ~a; b1 = b;
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      check({tag, ".busy_mid"}, {7'd0, busy}, 8'd1);
      check({tag, ".done_mid"}, {7'd0, done}, 8'd0);
    end
    @(negedge clk);
    check({tag, ".done"}, {7'd0, done}, 8'd1);
    check({tag, ".busy9"}, {7'd0, busy}, 8'd1);
    check({tag, ".eq"}, {7'd0, eq}, {7'd0, exp_eq});
    check({tag, ".done_id"}, {7'd0, done_id}, {7'd0, port});
    @(negedge clk);
    check({tag, ".done_off"}, {7'd0, done}, 8'd0);
    check({tag, ".busy_off"}, {7'd0, busy}, 8'd0);
    check({tag, ".eq_hold"}, {7'd0, eq}, {7'd0, exp_eq});
    check({tag, ".id_hold"}, {7'd0, done_id}, {7'd0, port});
  endtask

  initial begin
    rst_n = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;

    // Reset asserted between edges clears outputs immediately.
    #3 rst_n = 1'b0;
    #1 check_cleared("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_busy", {7'd0, busy}, 8'd0);
      check("idle_gnt", {6'd0, gnt}, 8'd0);
    end

    do_cmp("p0_equal", 1'b0, 8'hA5, 8'hA5, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("eq_held", {7'd0, eq}, 8'd1);
      check("id_held", {7'd0, done_id}, 8'd0);
    end
    do_cmp("p1_lsb_diff", 1'b1, 8'h3C, 8'h3D, 1'b0);
    do_cmp("p0_msb_diff", 1'b0, 8'h80, 8'h00, 1'b0);
    do_cmp("p0_all_ones", 1'b0, 8'hFF, 8'hFF, 1'b1);

    // Both ports held from reset: port 0 first, then strict alternation every 10 cycles.
    a0 = 8'h5A; b0 = 8'h5A; a1 = 8'h01; b1 = 8'h00;
    req0 = 1'b1; req1 = 1'b1;
    rst_n = 1'b0;
    #1 check_cleared("reset2");
    @(negedge clk);
    rst_n = 1'b1;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      check("alt_gnt", {6'd0, gnt}, (g % 2 == 1) ? 8'd2 : 8'd1);
      for (int c = 2; c <= 8; c++) begin
        @(negedge clk);
        check("alt_gnt_gap", {6'd0, gnt}, 8'd0);
      end
      @(negedge clk);
      check("alt_done", {7'd0, done}, 8'd1);
      check("alt_done_id", {7'd0, done_id}, (g % 2 == 1) ? 8'd1 : 8'd0);
      check("alt_eq", {7'd0, eq}, (g % 2 == 1) ? 8'd0 : 8'd1);
      @(negedge clk);
      check("alt_idle_busy", {7'd0, busy}, 8'd0);
    end
    req0 = 1'b0;

    // req1 still held: granted at the next edge; reset in SHIFT cycle 4 abandons it.
    a1 = 8'hC3; b1 = 8'hC3;
    @(negedge clk);
    check("abort_gnt", {6'd0, gnt}, 8'd2);
    repeat (3) @(negedge clk);
    check("abort_busy4", {7'd0, busy}, 8'd1);
    #1 rst_n = 1'b0;
    #1 check_cleared("abort_reset");
    @(negedge clk);
    check_cleared("abort_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check("rearb_gnt", {6'd0, gnt}, 8'd2);
    req1 = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      check("rearb_done_mid", {7'd0, done}, 8'd0);
    end
    @(negedge clk);
    check("rearb_done", {7'd0, done}, 8'd1);
    check("rearb_eq", {7'd0, eq}, 8'd1);
    check("rearb_id", {7'd0, done_id}, 8'd1);
    @(negedge clk);
    check("rearb_busy_off", {7'd0, busy}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
